// File: rtl/adder_rr_arbiter_pkg.sv
// Shared types and the round-robin pick function for the adder arbiter.
// Pure declarations; no timing or flow control of its own.
package adder_arb_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNT_W   = 16;
    localparam int MAX_REQ     = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    // First asserted index searching upward from ptr, wrapping at n.
    // Returns 0 when nothing is valid; callers gate with |valid.
    function automatic int unsigned rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        n
    );
        int unsigned idx;
        logic        found;
        found   = 1'b0;
        rr_pick = 0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n && !found) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[4:0]]) begin
                    found   = 1'b1;
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/adder_rr_arbiter_if.sv
// Request/response bundle between operand producers, the shared adder and its consumer.
// master = producers/consumer side, slave = arbiter side.
interface adder_rr_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_carry;
    logic [ID_W-1:0]          rsp_id;
    logic [CNT_W-1:0]         ops_done;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, ops_done
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, ops_done
    );

endinterface

// File: rtl/adder_rr_arbiter_core.sv
// Shared unsigned WIDTH-bit adder with carry-out.
// Latency 0 (purely combinational); no flow control.
module adder_core
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one adder; result, carry and winner ID land in a one-entry buffer.
// Latency 1 cycle; grants are withheld while the buffer is full and rsp_ready is low.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    adder_rr_arbiter_if.slave  bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] sum;
        logic [ID_W-1:0]  id;
    } rsp_t;

    buf_state_t       state;
    buf_state_t       state_nxt;
    rsp_t             rsp_q;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  ptr_nxt;
    logic [ID_W-1:0]  win_idx;
    logic [CNT_W-1:0] ops_cnt;
    logic             accept_en;
    logic             grant;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [WIDTH-1:0] sum;
    logic             carry;

    always_comb begin
        win_idx   = ID_W'(rr_pick(MAX_REQ'(bus.req_valid), 32'(rr_ptr), NUM_REQ));
        accept_en = (state == EMPTY) || bus.rsp_ready;
        grant     = accept_en && (|bus.req_valid);
        win_a     = bus.req_a[win_idx*WIDTH +: WIDTH];
        win_b     = bus.req_b[win_idx*WIDTH +: WIDTH];
        ptr_nxt   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end

    assign bus.req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;

    adder_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (win_a),
        .b     (win_b),
        .sum   (sum),
        .carry (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A handshake while FULL and draining reloads the buffer in place.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (grant) state_nxt = FULL;
            FULL:  if (bus.rsp_ready && !grant) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q   <= '0;
            rr_ptr  <= '0;
            ops_cnt <= '0;
        end else if (grant) begin
            rsp_q.carry <= carry;
            rsp_q.sum   <= sum;
            rsp_q.id    <= win_idx;
            rr_ptr      <= ptr_nxt;
            if (ops_cnt != '1) begin
                ops_cnt <= ops_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.rsp_valid = (state == FULL);
    assign bus.rsp_sum   = rsp_q.sum;
    assign bus.rsp_carry = rsp_q.carry;
    assign bus.rsp_id    = rsp_q.id;
    assign bus.ops_done  = ops_cnt;

endmodule
